// File: rtl/uart_piso_tx.sv
// -----------------------------------------------------------------------------
// uart_piso_tx
//   UART transmit path. It accepts one parallel word through a valid/ready
//   handshake and sends it on the serial line as one frame: a start bit, the
//   data bits (LSB first), an optional parity bit, and the stop bit(s). Each
//   serial bit is held for CLKS_PER_BIT cycles of baud_clk.
//
// Ports:
//   baud_clk    in   bit-rate clock; all state changes on its rising edge
//   rst_n       in   asynchronous active-low reset
//   tx_valid    in   a word is present on tx_data
//   tx_data     in   [DATA_BITS-1:0] word to transmit
//   tx_ready    out  high in IDLE, when a word can be accepted
//   data_tx     out  serial line; high when idle
//   active_flag out  high while a frame is on the line
//   done_flag   out  one-cycle pulse on the edge that returns to IDLE
// -----------------------------------------------------------------------------
module uart_piso_tx #(
  parameter int DATA_BITS    = 8,  // 5..9
  parameter int CLKS_PER_BIT = 2,  // >= 1
  parameter int PARITY_EN    = 1,  // 1 = append a parity bit
  parameter int PARITY_ODD   = 0,  // 1 = odd parity, 0 = even parity
  parameter int STOP_BITS    = 1   // 1 or 2
) (
  input  logic                 baud_clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 data_tx,
  output logic                 active_flag,
  output logic                 done_flag
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // One spare bit on the period counter so it can never wrap within a period.
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_data_tx;
  logic                 r_active;
  logic                 r_done;

  logic w_parity;
  logic w_period_end;

  // Even parity is the XOR of the word; odd parity is its inverse.
  assign w_parity     = (^tx_data) ^ (PARITY_ODD != 0);
  assign w_period_end = (r_clk_cnt == CLK_LAST);

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_data_tx <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (r_state == IDLE) begin
        r_data_tx <= 1'b1;
        r_clk_cnt <= '0;
        r_bit_cnt <= '0;
        if (tx_valid) begin
          // Handshake edge: the start bit goes out on this same edge, so a
          // handshake taken in the done cycle leaves exactly one idle-high
          // cycle between frames.
          r_shift   <= tx_data;
          r_parity  <= w_parity;
          r_state   <= START;
          r_data_tx <= 1'b0;
          r_active  <= 1'b1;
        end
      end else if (!w_period_end) begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end else begin
        r_clk_cnt <= '0;
        case (r_state)
          START: begin
            // Present bit 0 and pre-shift so r_shift[0] is always the next bit.
            r_state   <= DATA;
            r_bit_cnt <= '0;
            r_data_tx <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end
          DATA: begin
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_state   <= PARITY;
                r_data_tx <= r_parity;
              end else begin
                r_state   <= STOP;
                r_data_tx <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_data_tx <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
          PARITY: begin
            r_state   <= STOP;
            r_bit_cnt <= '0;
            r_data_tx <= 1'b1;
          end
          STOP: begin
            if (r_bit_cnt == STOP_LAST) begin
              r_state   <= IDLE;
              r_bit_cnt <= '0;
              r_active  <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            r_data_tx <= 1'b1;
          end
          default: begin
            r_state   <= IDLE;
            r_data_tx <= 1'b1;
            r_active  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready    = (r_state == IDLE);
  assign data_tx     = r_data_tx;
  assign active_flag = r_active;
  assign done_flag   = r_done;

endmodule
